// File: rtl/pattern_serializer_if.sv
// pattern_serializer_if
// Load-side valid/ready bundle for the pattern serializer.
//   load_valid : upstream offers load_data
//   load_data  : WIDTH-bit word, sampled only when the handshake fires
//   load_ready : serializer can take a word at the coming clock edge
// The master modport belongs to the word producer, the slave modport to
// the serializer.
interface pattern_serializer_if #(
    parameter int WIDTH = 8
);
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_ready;

    modport master (
        output load_valid,
        output load_data,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        output load_ready
    );
endinterface

// File: rtl/pattern_serializer.sv
// pattern_serializer
// Parallel-to-serial bit source for the serial input of a 101 sequence
// detector. A word taken over the load handshake is shifted out one bit per
// clock. A new word can be taken during the last bit of the current one, so
// words run back-to-back with no gap. With no word in flight, x sits at
// IDLE_BIT.
// Ports:
//   clk     : single rising-edge clock
//   clear_n : asynchronous active-low reset
//   load_if : slave side of the valid/ready/data load bundle
//   x       : serial output bit
//   busy    : a word is being shifted out
//   last    : the current x is the final bit of its word
module pattern_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic                 clk,
    input  logic                 clear_n,
    pattern_serializer_if.slave  load_if,
    output logic                 x,
    output logic                 busy,
    output logic                 last
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sreg_shifted;
    logic             load_fire;

    // Moves the next bit onto the output end and back-fills with zero.
    assign sreg_shifted = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0}
                                    : {1'b0, sreg_q[WIDTH-1:1]};

    // load_ready is decoded from state only, so the handshake never forms
    // a combinational path from load_valid back to load_ready.
    assign load_fire = load_if.load_valid & load_if.load_ready;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
        end
    end

    // A reload during the last bit keeps the FSM in SHIFT, which is what
    // makes the stream gapless.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (load_fire) begin
                    sreg_d  = load_if.load_data;
                    cnt_d   = CNT_LOAD;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    sreg_d = sreg_shifted;
                    cnt_d  = cnt_q - 1'b1;
                end else if (load_fire) begin
                    sreg_d  = load_if.load_data;
                    cnt_d   = CNT_LOAD;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        x                 = IDLE_BIT;
        busy              = 1'b0;
        last              = 1'b0;
        load_if.load_ready = 1'b1;
        if (state_q == SHIFT) begin
            busy               = 1'b1;
            last               = (cnt_q == '0);
            x                  = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
            load_if.load_ready = (cnt_q == '0);
        end
    end

endmodule

// File: doc/pattern_serializer.md
# pattern_serializer

Parallel-to-serial bit-stream source that feeds the serial input `x` of the 101 Moore sequence detector. It accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per clock. Consecutive words can be sent back-to-back with no gap. When no word is being shifted, the block drives a fixed idle level, so the detector never sees undefined or stale bits.

## Interface

Parameters:
- `WIDTH`, default 8: bits per word; must be ≥ 2.
- `MSB_FIRST`, default 1: 1 shifts bit WIDTH-1 first; 0 shifts bit 0 first.
- `IDLE_BIT`, default 0: level driven on `x` when no word is shifting.

Ports:
- `clk`: input, 1 bit. Single clock; all state updates on the rising edge.
- `clear_n`: input, 1 bit. Reset is asynchronous and active-low.
- `load_valid`: input, 1 bit. Upstream offers `load_data`.
- `load_data`: input, WIDTH bits. Word to serialize; sampled only on handshake.
- `load_ready`: output, 1 bit. Block can accept a word at the coming edge.
- `x`: output, 1 bit. Serial bit stream; connects to the detector `x`.
- `busy`: output, 1 bit. A word is being shifted out.
- `last`: output, 1 bit. The current `x` is the final bit of a word.

## Operation

- The handshake fires at a rising edge when `load_valid & load_ready` are both 1.
- State is held in three registers:
  - FSM register: IDLE or SHIFT.
  - Shift register `sreg`: WIDTH bits.
  - Bit counter `cnt`: $clog2(WIDTH) bits.
- Behaviour in IDLE:
  - Outputs: `load_ready`=1, `busy`=0, `last`=0, `x`=IDLE_BIT.
  - On handshake: `sreg`<=`load_data`, `cnt`<=WIDTH-1, next state SHIFT.
  - Without a handshake, IDLE holds.
- Behaviour in SHIFT:
  - Outputs: `busy`=1 and `last`=(`cnt`==0).
  - `x`=`sreg[WIDTH-1]` when MSB_FIRST=1; `x`=`sreg[0]` when MSB_FIRST=0.
  - While `cnt`≠0: `load_ready`=0. Each edge shifts `sreg` one position toward the output end, fills the vacated bit with 0, and decrements `cnt`.
  - While `cnt`==0 (last bit): `load_ready`=1.
    - Handshake at this edge: reload `sreg`/`cnt` as in IDLE and stay in SHIFT. This gives a gapless stream.
    - No handshake: next state IDLE.
- `load_ready` depends only on registered state, never combinationally on `load_valid`.
- When `load_ready`=0, `load_valid` and `load_data` are ignored. Upstream must hold `load_valid`/`load_data` stable until the handshake.
- `x`, `busy` and `last` are Moore outputs: decoded from registers only, glitch-free relative to inputs.
- Words concatenate in the stream. A 101 pattern spanning a word boundary is legitimate stream content, not an error.
- There is no abort input. `clear_n` is the only way to discard a word in flight.

## Timing

- Reset (`clear_n`=0, asynchronous, takes effect immediately):
  - State IDLE, `sreg`=0, `cnt`=0.
  - Outputs: `x`=IDLE_BIT, `load_ready`=1, `busy`=0, `last`=0.
- Release of `clear_n` is synchronous to `clk` in the system. The first handshake can happen at the first edge after release.
- Latency:
  - A handshake at edge k puts the first bit on `x` in the cycle following edge k. The detector samples that bit at edge k+1.
  - Bit i (0-based, in shift order) is valid between edges k+i and k+i+1.
  - `last` is high during bit WIDTH-1.
- Throughput: one word per WIDTH cycles with back-to-back loads; otherwise WIDTH cycles plus at least one IDLE cycle per word.
- Reset mid-word: the word is lost, outputs immediately take their reset values, and no partial bits follow the release.
- `load_valid` during the non-last bits of SHIFT: no effect. The word is accepted at the edge ending the last bit, or later from IDLE.

## Test plan

- Reset: assert `clear_n`=0 mid-SHIFT → outputs are immediately `x`=0, `busy`=0, `load_ready`=1, `last`=0. No bits appear after release until a load.
- Single word: WIDTH=8, MSB_FIRST=1, load 8'hA0 at edge k → `x`=1,0,1,0,0,0,0,0 over cycles k..k+7, `last` high only in cycle k+7, then `x`=0 and `busy`=0. A downstream 101 detector asserts `z` exactly once.
- Back-to-back: load 8'h81, then hold `load_valid`=1 with 8'h05 → the second word is accepted at the edge ending bit 7. `x`=1000000100000101 with no idle gap. `load_ready` is high only in `last` cycles and in IDLE.
- Stall: hold `load_valid`=1 with 8'hFF during bits 0–6 of a word, then change data to 8'h55 before the last-bit edge → 8'h55 is serialized. 8'hFF is never seen, and the current word is uncorrupted.
- LSB first: MSB_FIRST=0, load 8'h0D → `x`=1,0,1,1,0,0,0,0.
- Parameter sweep: WIDTH=2 and WIDTH=16 with random data and random `load_valid` gaps. The scoreboard checks every word appears in order, bit-exact, and `x`=IDLE_BIT in every cycle where `busy`=0.
